output_volume_ramp: RTL and testbench

OUTPUT_VOLUME_RAMP -- requirements
Module: output_volume_ramp

---
 rtl/output_volume_ramp.sv | 154 +++++++++++++++
 tb/tb_output_volume_ramp.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_volume_ramp.sv
// rtl/output_volume_ramp.sv - soft volume ramp and per-channel gain scaling for stereo PCM
//
// Scales left/right 24-bit signed PCM by an unsigned Q1.15 gain (16'h8000 = unity).
// The gain ramps toward its target by RAMP_STEP once per stereo frame (r_data_en),
// so audible volume and mute changes never step abruptly.
//
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   run                          audio enable; 0 forces mute and halts output
//   mute                         soft-mute request (ramps gain to zero)
//   vol_lsb, vol_msb             target gain {vol_msb, vol_lsb}, clamped to unity
//   l/r_data_en, l/r_data_in     input sample strobes and signed samples
//   l/r_data_valid, l/r_data_out scaled samples, valid two cycles after the strobe
//   ramp_busy, muted             registered state decodes

module output_volume_ramp #(
  parameter logic [15:0] RAMP_STEP = 16'h0040
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run,
  input  logic        mute,
  input  logic [7:0]  vol_lsb,
  input  logic [7:0]  vol_msb,
  input  logic        l_data_en,
  input  logic        r_data_en,
  input  logic [23:0] l_data_in,
  input  logic [23:0] r_data_in,
  output logic        l_data_valid,
  output logic        r_data_valid,
  output logic [23:0] l_data_out,
  output logic [23:0] r_data_out,
  output logic        ramp_busy,
  output logic        muted
);

  typedef enum logic [1:0] {
    ST_MUTED = 2'd0,
    ST_RAMP  = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cur_gain_q, cur_gain_d;
  logic [15:0] vol, target, stepped;
  logic        ramp_busy_q, muted_q;

  assign vol    = {vol_msb, vol_lsb};
  assign target = mute ? 16'h0000 : ((vol > 16'h8000) ? 16'h8000 : vol);

  // One ramp step toward target; lands exactly on target when within one step.
  always_comb begin
    stepped = target;
    if (cur_gain_q < target) begin
      if ((target - cur_gain_q) > RAMP_STEP) stepped = cur_gain_q + RAMP_STEP;
    end else begin
      if ((cur_gain_q - target) > RAMP_STEP) stepped = cur_gain_q - RAMP_STEP;
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_gain_d = cur_gain_q;
    unique case (state_q)
      ST_MUTED: begin
        cur_gain_d = 16'h0000;
        if (target != 16'h0000) state_d = ST_RAMP;
      end
      ST_HOLD: begin
        if (target != cur_gain_q) state_d = ST_RAMP;
      end
      ST_RAMP: begin
        // Gain only moves on the right strobe, so an L/R frame shares one gain.
        if (r_data_en) begin
          cur_gain_d = stepped;
          if (stepped == target) state_d = (target == 16'h0000) ? ST_MUTED : ST_HOLD;
        end
      end
      default: begin
        state_d    = ST_MUTED;
        cur_gain_d = 16'h0000;
      end
    endcase
    if (!run) begin
      state_d    = ST_MUTED;
      cur_gain_d = 16'h0000;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_MUTED;
      cur_gain_q  <= 16'h0000;
      ramp_busy_q <= 1'b0;
      muted_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cur_gain_q  <= cur_gain_d;
      ramp_busy_q <= (state_d == ST_RAMP);
      muted_q     <= (state_d == ST_MUTED);
    end
  end

  assign ramp_busy = ramp_busy_q;
  assign muted     = muted_q;

  // Two-stage datapath, index 0 = left, 1 = right.
  logic [1:0]        en;
  logic [1:0][23:0]  din;
  logic [1:0]        cap_v_q, out_v_q;
  logic [1:0][23:0]  cap_data_q, out_q;
  logic [1:0][15:0]  cap_gain_q;
  logic [1:0][23:0]  scaled;

  assign en  = {r_data_en, l_data_en};
  assign din = {r_data_in, l_data_in};

  // Signed 41-bit product, arithmetic shift floors toward minus infinity; gain
  // never exceeds unity so the low 24 bits hold the full result.
  always_comb begin
    scaled = '0;
    for (int ch = 0; ch < 2; ch++) begin
      scaled[ch] = 24'(($signed({{17{cap_data_q[ch][23]}}, cap_data_q[ch]}) *
                        $signed({25'd0, cap_gain_q[ch]})) >>> 15);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cap_v_q    <= 2'b00;
      out_v_q    <= 2'b00;
      cap_data_q <= '0;
      cap_gain_q <= '0;
      out_q      <= '0;
    end else begin
      cap_v_q <= run ? en : 2'b00;
      out_v_q <= run ? cap_v_q : 2'b00;
      for (int ch = 0; ch < 2; ch++) begin
        // Capture uses the pre-update gain, even when r_data_en steps it this edge.
        if (en[ch]) begin
          cap_data_q[ch] <= din[ch];
          cap_gain_q[ch] <= cur_gain_q;
        end
        if (run && cap_v_q[ch]) out_q[ch] <= scaled[ch];
      end
    end
  end

  assign l_data_valid = out_v_q[0];
  assign r_data_valid = out_v_q[1];
  assign l_data_out   = out_q[0];
  assign r_data_out   = out_q[1];

endmodule

// File: tb/tb_output_volume_ramp.sv
// tb/tb_output_volume_ramp.sv - randomized self-checking bench for output_volume_ramp

module tb_output_volume_ramp;

  localparam int STEP    = 'h40;
  localparam int M_MUTED = 0;
  localparam int M_RAMP  = 1;
  localparam int M_HOLD  = 2;

  logic        clk = 1'b0;
  logic        reset_n, run, mute;
  logic [7:0]  vol_lsb, vol_msb;
  logic        l_data_en, r_data_en;
  logic [23:0] l_data_in, r_data_in;
  logic        l_data_valid, r_data_valid;
  logic [23:0] l_data_out, r_data_out;
  logic        ramp_busy, muted;

  always #5 clk = ~clk;

  output_volume_ramp #(.RAMP_STEP(16'h0040)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .mute(mute),
    .vol_lsb(vol_lsb), .vol_msb(vol_msb),
    .l_data_en(l_data_en), .r_data_en(r_data_en),
    .l_data_in(l_data_in), .r_data_in(r_data_in),
    .l_data_valid(l_data_valid), .r_data_valid(r_data_valid),
    .l_data_out(l_data_out), .r_data_out(r_data_out),
    .ramp_busy(ramp_busy), .muted(muted)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: gain as an integer walking toward the target, and a list
  // of expected output samples tagged with the cycle in which they must appear.
  typedef struct {
    int          stamp;
    logic [23:0] v;
  } ent_t;

  ent_t        lq[$];
  ent_t        rq[$];
  int          mode = M_MUTED;
  int          gain = 0;
  int          cyc = 0;
  bit          armed = 0;
  logic [23:0] last_l = '0;
  logic [23:0] last_r = '0;

  function automatic logic [23:0] scale(input logic [23:0] d, input int g);
    longint sd;
    longint p;
    sd = $signed(d);
    p  = (sd * longint'(g)) >>> 15;
    return p[23:0];
  endfunction

  always @(posedge clk) begin
    logic [15:0] v;
    int tgt, delta;
    cyc++;
    if (!reset_n) begin
      armed = 1;
      mode  = M_MUTED;
      gain  = 0;
      lq.delete();
      rq.delete();
      last_l = '0;
      last_r = '0;
    end else if (!run) begin
      mode = M_MUTED;
      gain = 0;
      lq.delete();
      rq.delete();
    end else begin
      v   = {vol_msb, vol_lsb};
      tgt = mute ? 0 : ((v > 16'h8000) ? 'h8000 : int'(v));
      if (l_data_en) lq.push_back('{stamp: cyc + 1, v: scale(l_data_in, gain)});
      if (r_data_en) rq.push_back('{stamp: cyc + 1, v: scale(r_data_in, gain)});
      case (mode)
        M_MUTED: if (tgt != 0) mode = M_RAMP;
        M_HOLD:  if (tgt != gain) mode = M_RAMP;
        default: if (r_data_en) begin
          delta = tgt - gain;
          if (delta > STEP) delta = STEP;
          if (delta < -STEP) delta = -STEP;
          gain += delta;
          if (gain == tgt) mode = (tgt == 0) ? M_MUTED : M_HOLD;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      if (lq.size() > 0 && lq[0].stamp == cyc) begin
        check("l_valid", {31'd0, l_data_valid}, 32'd1);
        check("l_data", {8'd0, l_data_out}, {8'd0, lq[0].v});
        last_l = lq[0].v;
        void'(lq.pop_front());
      end else begin
        check("l_valid_idle", {31'd0, l_data_valid}, 32'd0);
        check("l_hold", {8'd0, l_data_out}, {8'd0, last_l});
      end
      if (rq.size() > 0 && rq[0].stamp == cyc) begin
        check("r_valid", {31'd0, r_data_valid}, 32'd1);
        check("r_data", {8'd0, r_data_out}, {8'd0, rq[0].v});
        last_r = rq[0].v;
        void'(rq.pop_front());
      end else begin
        check("r_valid_idle", {31'd0, r_data_valid}, 32'd0);
        check("r_hold", {8'd0, r_data_out}, {8'd0, last_r});
      end
      check("ramp_busy", {31'd0, ramp_busy}, {31'd0, mode == M_RAMP});
      check("muted", {31'd0, muted}, {31'd0, mode == M_MUTED});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    l_data_en = 1'b0;
    r_data_en = 1'b0;
  endtask

  task automatic set_vol(input logic [15:0] v);
    {vol_msb, vol_lsb} = v;
  endtask

  // One stereo frame with random samples and random L/R alignment.
  task automatic frame();
    l_data_in = 24'($urandom);
    r_data_in = 24'($urandom);
    case ($urandom_range(0, 2))
      0: begin l_data_en = 1'b1; r_data_en = 1'b1; tick(); end
      1: begin l_data_en = 1'b1; tick(); r_data_en = 1'b1; tick(); end
      default: begin l_data_en = 1'b1; tick(); tick(); r_data_en = 1'b1; tick(); end
    endcase
  endtask

  task automatic strobe_l_expect(input string tag, input logic [23:0] d, input logic [23:0] exp);
    l_data_in = d;
    l_data_en = 1'b1;
    tick();
    tick();
    check({tag, "_valid"}, {31'd0, l_data_valid}, 32'd1);
    check(tag, {8'd0, l_data_out}, {8'd0, exp});
  endtask

  initial begin
    reset_n = 1'b0; run = 1'b0; mute = 1'b0; set_vol(16'h0000);
    l_data_en = 1'b0; r_data_en = 1'b0; l_data_in = '0; r_data_in = '0;
    repeat (3) tick();
    check("rst_muted", {31'd0, muted}, 32'd1);
    check("rst_busy", {31'd0, ramp_busy}, 32'd0);
    check("rst_lvalid", {31'd0, l_data_valid}, 32'd0);
    check("rst_lout", {8'd0, l_data_out}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Ramp to unity over 512 frames.
    run = 1'b1; set_vol(16'h8000);
    tick();
    check("ramp_start_busy", {31'd0, ramp_busy}, 32'd1);
    repeat (512) frame();
    tick();
    check("unity_busy", {31'd0, ramp_busy}, 32'd0);
    check("unity_muted", {31'd0, muted}, 32'd0);
    strobe_l_expect("unity_123456", 24'h123456, 24'h123456);
    strobe_l_expect("unity_800000", 24'h800000, 24'h800000);

    // Half gain.
    set_vol(16'h4000);
    tick();
    repeat (260) frame();
    tick();
    strobe_l_expect("half_7ffffe", 24'h7FFFFE, 24'h3FFFFF);

    // Soft mute from half gain.
    mute = 1'b1;
    tick();
    check("mute_busy", {31'd0, ramp_busy}, 32'd1);
    repeat (256) frame();
    tick();
    check("mute_done", {31'd0, muted}, 32'd1);
    strobe_l_expect("muted_out", 24'h7FFFFE, 24'h000000);

    // Over-range volume clamps to unity.
    mute = 1'b0; set_vol(16'hFFFF);
    tick();
    repeat (515) frame();
    tick();
    check("clamp_busy", {31'd0, ramp_busy}, 32'd0);
    strobe_l_expect("clamp_unity", 24'h654321, 24'h654321);

    // Small target from zero: 0x40 then clamped at 0x50.
    mute = 1'b1;
    tick();
    repeat (515) frame();
    tick();
    set_vol(16'h0050); mute = 1'b0;
    tick();
    frame();
    frame();
    tick();
    check("small_busy", {31'd0, ramp_busy}, 32'd0);
    check("small_muted", {31'd0, muted}, 32'd0);
    strobe_l_expect("small_gain", 24'h7FFFFE, 24'h004FFF);

    // Coincident strobes mid-ramp.
    set_vol(16'h8000);
    tick();
    frame();
    l_data_in = 24'h100000; r_data_in = 24'h100000;
    l_data_en = 1'b1; r_data_en = 1'b1;
    tick();
    tick();
    check("coinc_lvalid", {31'd0, l_data_valid}, 32'd1);
    check("coinc_rvalid", {31'd0, r_data_valid}, 32'd1);
    check("coinc_equal", {8'd0, l_data_out}, {8'd0, r_data_out});

    // Run dropped with a sample in flight, then ramp restart from zero.
    l_data_in = 24'h7FFFFE; l_data_en = 1'b1;
    tick();
    run = 1'b0;
    tick();
    check("rundrop_valid", {31'd0, l_data_valid}, 32'd0);
    check("rundrop_muted", {31'd0, muted}, 32'd1);
    l_data_en = 1'b1;
    tick();
    tick();
    check("rundrop_ignored", {31'd0, l_data_valid}, 32'd0);
    run = 1'b1;
    tick();
    check("restart_busy", {31'd0, ramp_busy}, 32'd1);
    r_data_en = 1'b1;
    tick();
    strobe_l_expect("restart_gain", 24'h7FFFFE, 24'h003FFF);

    // Random traffic with volume, mute, run and reset disturbances.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0)
        set_vol($urandom_range(0, 3) == 0 ? 16'($urandom) : 16'($urandom_range(0, 16'h8000)));
      if ($urandom_range(0, 299) == 0) mute = ~mute;
      if ($urandom_range(0, 399) == 0) run = ~run;
      if (!run && $urandom_range(0, 7) == 0) run = 1'b1;
      reset_n = ($urandom_range(0, 799) != 0);
      l_data_en = ($urandom_range(0, 2) == 0);
      r_data_en = ($urandom_range(0, 2) == 0);
      l_data_in = 24'($urandom);
      r_data_in = 24'($urandom);
      @(posedge clk);
      #2;
    end
    reset_n = 1'b1; l_data_en = 1'b0; r_data_en = 1'b0;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
